nand_gate_bist: RTL and testbench

NAND_GATE_BIST -- requirements
Module: nand_gate_bist

---
 rtl/nand_gate_bist.sv | 160 ++++++++++++++++
 tb/tb_nand_gate_bist.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_gate_bist.sv
// nand_gate_bist: sweeps {a,b} through 00..11 into an eight-gate bank and
// checks every response bit against the golden truth table.
//
// state  | meaning
// IDLE   | a/b low, results held, waiting for start
// APPLY  | vector driven, settle timer counting down
// SAMPLE | vector still driven, y_in compared against golden
// DONE   | one-cycle completion pulse, pass resolved
module nand_gate_bist #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned PASSES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic [7:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_mask,
  output logic [1:0] err_vec,
  output logic [7:0] err_cnt
);

  // A zero setting is treated like the minimum legal value of one.
  localparam logic [3:0] SETTLE_LD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [3:0] LAST_PASS = (PASSES == 0) ? 4'd0 : 4'(PASSES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] vec;
  logic [3:0] pass_cnt;
  logic [3:0] settle_cnt;
  logic [7:0] golden;
  logic [7:0] mism;
  logic       hit;
  logic       last_sample;
  logic [7:0] err_cnt_nxt;

  function automatic logic [7:0] golden_resp(input logic [1:0] v);
    logic a;
    logic b;
    a = v[1];
    b = v[0];
    golden_resp = {~(a & b), ~(a ^ b), a ^ b, ~(a | b), a | b, a & b, ~b, ~a};
  endfunction

  always_comb begin
    golden      = golden_resp(vec);
    mism        = y_in ^ golden;
    hit         = (state == SAMPLE) && (mism != 8'h00);
    last_sample = (vec == 2'b11) && (pass_cnt == LAST_PASS);
    err_cnt_nxt = err_cnt;
    if (hit && (err_cnt != 8'hFF)) begin
      err_cnt_nxt = err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    a_out     = 1'b0;
    b_out     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        busy  = 1'b1;
        a_out = vec[1];
        b_out = vec[0];
        if (settle_cnt == 4'd0) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        busy      = 1'b1;
        a_out     = vec[1];
        b_out     = vec[0];
        state_nxt = last_sample ? DONE : APPLY;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= 2'b00;
      pass_cnt   <= 4'd0;
      settle_cnt <= 4'd0;
      err_mask   <= 8'h00;
      err_vec    <= 2'b00;
      err_cnt    <= 8'h00;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec        <= 2'b00;
            pass_cnt   <= 4'd0;
            settle_cnt <= SETTLE_LD;
            err_mask   <= 8'h00;
            err_vec    <= 2'b00;
            err_cnt    <= 8'h00;
            pass       <= 1'b0;
          end
        end
        APPLY: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        SAMPLE: begin
          // An empty mask means no earlier sample in this run has mismatched.
          if (hit) begin
            err_mask <= err_mask | mism;
            if (err_mask == 8'h00) begin
              err_vec <= vec;
            end
          end
          err_cnt    <= err_cnt_nxt;
          vec        <= vec + 2'd1;
          settle_cnt <= SETTLE_LD;
          if (vec == 2'b11) begin
            pass_cnt <= pass_cnt + 4'd1;
          end
          if (last_sample) begin
            pass <= (err_cnt_nxt == 8'h00);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_gate_bist.sv
// Self-checking bench for nand_gate_bist: table of gate-bank faults on the
// default instance plus directed runs for timing, reset and saturation.
module tb_nand_gate_bist;

  typedef struct packed {
    logic [7:0] mask;
    logic [1:0] vec;
    logic [7:0] cnt;
    logic       pass;
  } res_t;

  typedef struct packed {
    logic [7:0] and_m;
    logic [7:0] or_m;
    logic [7:0] xor_m;
    res_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  res_t sb[$];
  vec_t tbl[8];

  // instance 0: SETTLE=2 PASSES=2, faultable bank
  logic       start0 = 1'b0;
  logic       a0, b0, busy0, done0, pass0;
  logic [7:0] y0, err_mask0, err_cnt0;
  logic [1:0] err_vec0;
  logic [7:0] and0 = 8'hFF, or0 = 8'h00, xor0 = 8'h00;

  // instance 1: SETTLE=1 PASSES=1, good bank
  logic       start1 = 1'b0;
  logic       a1, b1, busy1, done1, pass1;
  logic [7:0] y1, err_mask1, err_cnt1;
  logic [1:0] err_vec1;

  // instance 2: SETTLE=2 PASSES=15, inverting bank
  logic       start2 = 1'b0;
  logic       a2, b2, busy2, done2, pass2;
  logic [7:0] y2, err_mask2, err_cnt2;
  logic [1:0] err_vec2;
  logic [7:0] xor2 = 8'h00;

  function automatic logic [7:0] gate_ref(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 8'hD3;
      2'b01:   return 8'hA9;
      2'b10:   return 8'hAA;
      default: return 8'h4C;
    endcase
  endfunction

  assign y0 = ((gate_ref(a0, b0) & and0) | or0) ^ xor0;
  assign y1 = gate_ref(a1, b1);
  assign y2 = gate_ref(a2, b2) ^ xor2;

  nand_gate_bist #(.SETTLE(2), .PASSES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a_out(a0), .b_out(b0),
    .y_in(y0), .busy(busy0), .done(done0), .pass(pass0),
    .err_mask(err_mask0), .err_vec(err_vec0), .err_cnt(err_cnt0)
  );

  nand_gate_bist #(.SETTLE(1), .PASSES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1),
    .y_in(y1), .busy(busy1), .done(done1), .pass(pass1),
    .err_mask(err_mask1), .err_vec(err_vec1), .err_cnt(err_cnt1)
  );

  nand_gate_bist #(.SETTLE(2), .PASSES(15)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2),
    .y_in(y2), .busy(busy2), .done(done2), .pass(pass2),
    .err_mask(err_mask2), .err_vec(err_vec2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [7:0] m, input logic [1:0] v,
                         input logic [7:0] c, input logic p);
    res_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_err_mask"}, 32'(m), 32'(e.mask));
      chk({tag, "_err_vec"},  32'(v), 32'(e.vec));
      chk({tag, "_err_cnt"},  32'(c), 32'(e.cnt));
      chk({tag, "_pass"},     32'(p), 32'(e.pass));
    end
  endtask

  task automatic run_u0(input res_t e, input bit poke);
    int busy_cycles;
    int waited;
    busy_cycles = 0;
    waited = 0;
    sb.push_back(e);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    while (!done0 && waited < 400) begin
      if (busy0) busy_cycles++;
      start0 = poke && (waited == 5);
      waited++;
      @(negedge clk);
    end
    start0 = 1'b0;
    chk("u0_done_seen", 32'(done0), 32'd1);
    chk("u0_busy_len", busy_cycles, 32'd24);
    chk("u0_ab_in_done", 32'({a0, b0}), 32'd0);
    chk_res("u0", err_mask0, err_vec0, err_cnt0, pass0);
    // results must hold in IDLE whatever the bank returns
    xor0 = ~xor0;
    @(negedge clk);
    chk("u0_done_width", 32'(done0), 32'd0);
    repeat (3) @(negedge clk);
    chk("u0_hold_cnt", 32'(err_cnt0), 32'(e.cnt));
    chk("u0_hold_pass", 32'(pass0), 32'(e.pass));
    xor0 = ~xor0;
  endtask

  initial begin
    int dones;
    int waited;
    int busy_cycles;

    //                and    or     xor    mask   vec    cnt   pass
    tbl[0] = '{8'hFF, 8'h00, 8'h00, '{8'h00, 2'b00, 8'd0, 1'b1}};
    tbl[1] = '{8'hDF, 8'h00, 8'h00, '{8'h20, 2'b01, 8'd4, 1'b0}};
    tbl[2] = '{8'hFF, 8'h00, 8'hFF, '{8'hFF, 2'b00, 8'd8, 1'b0}};
    tbl[3] = '{8'hFF, 8'h00, 8'h01, '{8'h01, 2'b00, 8'd8, 1'b0}};
    tbl[4] = '{8'hFF, 8'h04, 8'h00, '{8'h04, 2'b00, 8'd6, 1'b0}};
    tbl[5] = '{8'hFF, 8'h40, 8'h00, '{8'h40, 2'b01, 8'd4, 1'b0}};
    tbl[6] = '{8'hF7, 8'h10, 8'h00, '{8'h18, 2'b01, 8'd6, 1'b0}};
    tbl[7] = '{8'hFB, 8'h00, 8'h00, '{8'h04, 2'b11, 8'd2, 1'b0}};

    #23;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_pass", 32'(pass0), 32'd0);
    chk("rst_outs", 32'({a0, b0, err_vec0, err_mask0, err_cnt0}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      and0 = tbl[i].and_m;
      or0  = tbl[i].or_m;
      xor0 = tbl[i].xor_m;
      run_u0(tbl[i].exp, (i == 1));
    end

    // start held high: back-to-back runs, each with freshly cleared results
    and0 = tbl[1].and_m; or0 = tbl[1].or_m; xor0 = tbl[1].xor_m;
    repeat (3) sb.push_back(tbl[1].exp);
    dones = 0;
    @(negedge clk); start0 = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 60) start0 = 1'b0;
      if (done0) begin
        dones++;
        chk_res("b2b", err_mask0, err_vec0, err_cnt0, pass0);
      end
    end
    start0 = 1'b0;
    chk("b2b_done_count", dones, 32'd3);
    chk("b2b_sb_drained", 32'(sb.size()), 32'd0);

    // asynchronous reset in APPLY of vector 01
    and0 = tbl[2].and_m; or0 = tbl[2].or_m; xor0 = tbl[2].xor_m;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_cnt", 32'(err_cnt0), 32'd1);
    chk("pre_rst_ab", 32'({a0, b0}), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_ab", 32'({a0, b0}), 32'd0);
    chk("arst_cnt", 32'(err_cnt0), 32'd0);
    chk("arst_mask", 32'(err_mask0), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    busy_cycles = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done0) dones++;
      if (busy0) busy_cycles++;
    end
    chk("arst_no_done", dones, 32'd0);
    chk("arst_idle", busy_cycles, 32'd0);
    and0 = tbl[0].and_m; or0 = tbl[0].or_m; xor0 = tbl[0].xor_m;
    run_u0(tbl[0].exp, 1'b0);

    // SETTLE=1 PASSES=1 stimulus sequence
    sb.push_back('{8'h00, 2'b00, 8'd0, 1'b1});
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("u1_ab_cyc%0d", i + 1), 32'({a1, b1}), i / 2);
      chk($sformatf("u1_busy_cyc%0d", i + 1), 32'({busy1, done1}), 32'd2);
      @(negedge clk);
    end
    chk("u1_done_cyc9", 32'(done1), 32'd1);
    chk("u1_ab_cyc9", 32'({a1, b1}), 32'd0);
    chk_res("u1", err_mask1, err_vec1, err_cnt1, pass1);

    // PASSES=15, fully inverted bank
    xor2 = 8'hFF;
    sb.push_back('{8'hFF, 2'b00, 8'd60, 1'b0});
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    waited = 0;
    busy_cycles = 0;
    while (!done2 && waited < 1000) begin
      if (busy2) busy_cycles++;
      waited++;
      @(negedge clk);
    end
    chk("u2_done_seen", 32'(done2), 32'd1);
    chk("u2_busy_len", busy_cycles, 32'd180);
    chk_res("u2", err_mask2, err_vec2, err_cnt2, pass2);

    // counter preloaded near the top must stick at 255
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    force u2.err_cnt = 8'd254;
    #1 release u2.err_cnt;
    waited = 0;
    while (!done2 && waited < 1000) begin
      waited++;
      @(negedge clk);
    end
    chk("sat_done_seen", 32'(done2), 32'd1);
    chk("sat_err_cnt", 32'(err_cnt2), 32'd255);
    chk("sat_pass", 32'(pass2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
